// File: rtl/mpu_matrix_regfile_if.sv
// Load-stream and element-read bus of the matrix register file.
// The master side is the load stage plus the store/multiply engines.
// The slave side is the register file.
interface mpu_matrix_regfile_if #(
    parameter int MBITS           = 2,
    parameter int NBITS           = 2,
    parameter int MATRIX_REG_BITS = 2,
    parameter int NUM_MATRIX      = 4
) ();
    logic                       load_ready_out;
    logic                       load_en_in;
    logic [MATRIX_REG_BITS:0]   load_addr_in;
    logic [31:0]                load_element_in;
    logic [MBITS:0]             load_i_in;
    logic [NBITS:0]             load_j_in;
    logic [MBITS:0]             load_m_in;
    logic [NBITS:0]             load_n_in;
    logic                       load_error_out;
    logic                       read_req_in;
    logic [MATRIX_REG_BITS:0]   read_addr_in;
    logic [MBITS:0]             read_i_in;
    logic [NBITS:0]             read_j_in;
    logic [31:0]                read_element_out;
    logic [MBITS:0]             read_m_out;
    logic [NBITS:0]             read_n_out;
    logic                       read_valid_out;
    logic                       read_error_out;
    logic [NUM_MATRIX-1:0]      matrix_valid_out;

    modport master (
        input  load_ready_out, load_error_out,
        output load_en_in, load_addr_in, load_element_in, load_i_in, load_j_in, load_m_in, load_n_in,
        output read_req_in, read_addr_in, read_i_in, read_j_in,
        input  read_element_out, read_m_out, read_n_out, read_valid_out, read_error_out,
        input  matrix_valid_out
    );

    modport slave (
        output load_ready_out, load_error_out,
        input  load_en_in, load_addr_in, load_element_in, load_i_in, load_j_in, load_m_in, load_n_in,
        input  read_req_in, read_addr_in, read_i_in, read_j_in,
        output read_element_out, read_m_out, read_n_out, read_valid_out, read_error_out,
        output matrix_valid_out
    );
endinterface

// File: rtl/mpu_matrix_regfile.sv
// Matrix register file: stores NUM_MATRIX matrices of up to M x N single-precision
// elements. The file accepts an element-serial load stream and keeps a size and a
// fully-loaded flag for each slot. It serves a registered element read with 1-cycle latency.
module mpu_matrix_regfile #(
    parameter int M               = 4,
    parameter int N               = 4,
    parameter int MBITS           = 2,
    parameter int NBITS           = 2,
    parameter int MATRIX_REG_BITS = 2,
    parameter int NUM_MATRIX      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mpu_matrix_regfile_if.slave  bus
);
    localparam int AW = (NUM_MATRIX > 1) ? $clog2(NUM_MATRIX) : 1;
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;

    localparam logic [MATRIX_REG_BITS:0] NUM_MATRIX_L = (MATRIX_REG_BITS+1)'(NUM_MATRIX);
    localparam logic [MBITS:0]           M_L          = (MBITS+1)'(M);
    localparam logic [NBITS:0]           N_L          = (NBITS+1)'(N);
    localparam logic [MBITS:0]           M_ONE        = (MBITS+1)'(1);
    localparam logic [NBITS:0]           N_ONE        = (NBITS+1)'(1);

    typedef enum logic [0:0] {
        RF_IDLE = 1'b0,
        RF_LOAD = 1'b1
    } rf_state_t;

    rf_state_t                  state_r;
    logic [MATRIX_REG_BITS:0]   active_addr_r;
    logic [NUM_MATRIX-1:0]      valid_r;
    logic [MBITS:0]             size_m_r [NUM_MATRIX];
    logic [NBITS:0]             size_n_r [NUM_MATRIX];
    logic [31:0]                mem_r [NUM_MATRIX][M][N];
    logic                       load_error_r;
    logic                       read_valid_r;
    logic                       read_error_r;
    logic [31:0]                read_element_r;
    logic [MBITS:0]             read_m_r;
    logic [NBITS:0]             read_n_r;

    logic                       wr_fmt_bad_s;
    logic                       wr_addr_bad_s;
    logic                       wr_ok_s;
    logic                       wr_last_s;
    logic                       rd_fail_s;
    logic [31:0]                rd_data_s;

    // Slot/row/column indices, truncated to the storage index width.
    // Out-of-range values are only used under a rejected condition.
    logic [AW-1:0] wa_s;
    logic [IW-1:0] wi_s;
    logic [JW-1:0] wj_s;
    logic [AW-1:0] ra_s;
    logic [IW-1:0] ri_s;
    logic [JW-1:0] rj_s;

    assign wa_s = bus.load_addr_in[AW-1:0];
    assign wi_s = bus.load_i_in[IW-1:0];
    assign wj_s = bus.load_j_in[JW-1:0];
    assign ra_s = bus.read_addr_in[AW-1:0];
    assign ri_s = bus.read_i_in[IW-1:0];
    assign rj_s = bus.read_j_in[JW-1:0];

    // Qualify the incoming write and read against the format, slot and load-ownership rules.
    always_comb begin
        wr_fmt_bad_s  = (bus.load_addr_in >= NUM_MATRIX_L) ||
                        (bus.load_m_in == '0) || (bus.load_n_in == '0) ||
                        (bus.load_m_in > M_L) || (bus.load_n_in > N_L) ||
                        (bus.load_i_in >= bus.load_m_in) || (bus.load_j_in >= bus.load_n_in);
        wr_addr_bad_s = (state_r == RF_LOAD) && (bus.load_addr_in != active_addr_r);
        if (bus.load_en_in) begin
            wr_ok_s = !(wr_fmt_bad_s || wr_addr_bad_s);
        end else begin
            wr_ok_s = 1'b0;
        end
        wr_last_s = (bus.load_i_in == (bus.load_m_in - M_ONE)) &&
                    (bus.load_j_in == (bus.load_n_in - N_ONE));
        // A slot being written (now or by the ongoing load) is never readable.
        rd_fail_s = (bus.read_addr_in >= NUM_MATRIX_L) || !valid_r[ra_s] ||
                    (bus.read_i_in >= size_m_r[ra_s]) || (bus.read_j_in >= size_n_r[ra_s]) ||
                    ((state_r == RF_LOAD) && (bus.read_addr_in == active_addr_r)) ||
                    (bus.load_en_in && (bus.load_addr_in == bus.read_addr_in));
        rd_data_s = mem_r[ra_s][ri_s][rj_s];
    end

    // Load FSM, slot status, size table and registered read/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RF_IDLE;
            active_addr_r  <= '0;
            valid_r        <= '0;
            load_error_r   <= 1'b0;
            read_valid_r   <= 1'b0;
            read_error_r   <= 1'b0;
            read_element_r <= 32'h0000_0000;
            read_m_r       <= '0;
            read_n_r       <= '0;
            for (int k = 0; k < NUM_MATRIX; k++) begin
                size_m_r[k] <= '0;
                size_n_r[k] <= '0;
            end
        end else begin
            case (state_r)
                RF_IDLE: begin
                    if (bus.load_en_in) begin
                        state_r       <= RF_LOAD;
                        active_addr_r <= bus.load_addr_in;
                    end else begin
                        state_r       <= RF_IDLE;
                    end
                end
                RF_LOAD: begin
                    if (bus.load_en_in) begin
                        state_r <= RF_LOAD;
                    end else begin
                        state_r <= RF_IDLE;
                    end
                end
                default: begin
                    state_r <= RF_IDLE;
                end
            endcase
            load_error_r <= bus.load_en_in && !wr_ok_s;
            // A slot is invalid while any non-final element lands; the final one validates it.
            if (wr_ok_s) begin
                size_m_r[wa_s] <= bus.load_m_in;
                size_n_r[wa_s] <= bus.load_n_in;
                valid_r[wa_s]  <= wr_last_s;
            end
            read_valid_r <= bus.read_req_in && !rd_fail_s;
            read_error_r <= bus.read_req_in && rd_fail_s;
            if (bus.read_req_in && !rd_fail_s) begin
                read_element_r <= rd_data_s;
                read_m_r       <= size_m_r[ra_s];
                read_n_r       <= size_n_r[ra_s];
            end
        end
    end

    // Element storage is deliberately not reset; the valid flags guard every read.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wa_s][wi_s][wj_s] <= bus.load_element_in;
        end
    end

    assign bus.load_ready_out   = (state_r == RF_IDLE);
    assign bus.load_error_out   = load_error_r;
    assign bus.read_valid_out   = read_valid_r;
    assign bus.read_error_out   = read_error_r;
    assign bus.read_element_out = read_element_r;
    assign bus.read_m_out       = read_m_r;
    assign bus.read_n_out       = read_n_r;
    assign bus.matrix_valid_out = valid_r;
endmodule
